// File: rtl/mem_responder_pkg.sv
// Shared encodings and defaults for the memory responder slice.
package mem_responder_pkg;
  localparam int DEPTH_DEF   = 256;
  localparam int LATENCY_DEF = 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] wdata;
  } mreq_t;

  // Reserved size is reported as an alignment fault.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = a[0];
      SZ_WORD: misaligned = |a;
      default: misaligned = 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/mem_lane_merge.sv
// Little-endian lane steering: merged store word and extended load value.
module mem_lane_merge
  import mem_responder_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  output logic [31:0] wmerged,
  output logic [31:0] rext
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    wmerged = old_word;
    rext    = old_word;
    b       = old_word[{lane, 3'b000} +: 8];
    h       = old_word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        wmerged[{lane, 3'b000} +: 8] = wdata[7:0];
        rext = {{24{sign_ext & b[7]}}, b};
      end
      SZ_HALF: begin
        wmerged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        rext = {{16{sign_ext & h[15]}}, h};
      end
      default: wmerged = wdata;
    endcase
  end
endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder: accept, fixed wait-state latency, one-cycle ack.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err_align,
  output logic        err_range
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(LATENCY + 1);

  state_e         state, state_nx;
  mreq_t          rq;
  logic [CW-1:0]  cnt;
  logic           ea_q, er_q;
  logic           ea_in, er_in, good;
  logic [IW-1:0]  widx;
  logic [31:0]    old_word, wmerged, rext;
  logic [31:0]    mem [DEPTH];

  assign ea_in = misaligned(size, addr[1:0]);
  assign er_in = {2'b00, addr[31:2]} >= 32'(DEPTH);
  assign good  = !ea_q && !er_q;
  assign widx  = rq.addr[IW+1:2];
  assign old_word = mem[widx];

  mem_lane_merge u_merge (
    .old_word (old_word),
    .wdata    (rq.wdata),
    .size     (rq.size),
    .lane     (rq.addr[1:0]),
    .sign_ext (rq.sign_ext),
    .wmerged  (wmerged),
    .rext     (rext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      rq    <= '0;
      cnt   <= '0;
      ea_q  <= 1'b0;
      er_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: if (req) begin
          rq   <= '{addr: addr, we: we, size: size, sign_ext: sign_ext, wdata: wdata};
          ea_q <= ea_in;
          er_q <= er_in;
          cnt  <= CW'(LATENCY - 1);
        end
        ST_WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (req) state_nx = (ea_in || er_in) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == '0) state_nx = ST_RESP;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Reset level gates the commit so a reset landing on the RESP edge drops the write.
  always_ff @(posedge clk) begin
    if (reset && state == ST_RESP && rq.we && good)
      mem[widx] <= wmerged;
  end

  assign ack       = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign err_align = ack && ea_q;
  assign err_range = ack && er_q;
  assign rdata     = (ack && !rq.we && good) ? rext : 32'h0;
endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a word-array reference model.
module tb_mem_responder;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        ack, busy, err_align, err_range;

  int errs = 0, checks = 0;
  int cyc = 0;
  logic [31:0] ref_mem [DEPTH];

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy),
    .err_align(err_align), .err_range(err_range)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected load value straight from the size/lane/extension rules.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sx, input logic [1:0] a);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = (w >> (8 * a)) & 32'hFF;
        if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (w >> (16 * a[1])) & 32'hFFFF;
        if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] d,
                                            input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] m;
    int sh;
    case (sz)
      2'd0: begin m = 32'hFF;   sh = 8 * a; end
      2'd1: begin m = 32'hFFFF; sh = 16 * a[1]; end
      default: begin m = 32'hFFFF_FFFF; sh = 0; end
    endcase
    return (w & ~(m << sh)) | ((d & m) << sh);
  endfunction

  task automatic txn(input logic w, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] d);
    logic ea, er;
    logic [31:0] old, exp_rd;
    int lat, n;
    ea  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    er  = a[31:2] >= DEPTH;
    lat = (ea || er) ? 1 : LATENCY + 1;
    old = er ? 32'h0 : ref_mem[a[9:2]];
    exp_rd = (w || ea || er) ? 32'h0 : ref_load(old, sz, sx, a[1:0]);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    n = 0;
    forever begin
      n++;
      @(negedge clk);
      if (ack || n >= 20) break;
      @(posedge clk);
    end
    chk("ack_latency", 32'(n), 32'(lat));
    chk("rdata", rdata, exp_rd);
    chk("err_align", {31'b0, err_align}, {31'b0, ea});
    chk("err_range", {31'b0, err_range}, {31'b0, er});
    if (w && !ea && !er) ref_mem[a[9:2]] = ref_store(old, d, sz, a[1:0]);
  endtask

  initial begin
    int acks [$];
    logic [31:0] a;
    logic [1:0] sz;
    #1;
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_errs", {30'b0, err_align, err_range}, 32'h0);
    #20 reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) txn(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom);

    // Directed sequence
    txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("dir_word", ref_mem[4], 32'hDEAD_BEEF);
    txn(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AA);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    txn(1'b0, 2'd0, 1'b1, 32'h12, 32'h0);
    txn(1'b0, 2'd0, 1'b0, 32'h12, 32'h0);
    txn(1'b0, 2'd1, 1'b1, 32'h11, 32'h0);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    txn(1'b1, 2'd2, 1'b0, 32'h400, 32'h1111_2222);
    txn(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    txn(1'b0, 2'd3, 1'b0, 32'h8, 32'h0);

    // req held high: one accept per transaction, acks LATENCY+2 apart
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h10;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (ack) begin
        acks.push_back(cyc);
        chk("held_rdata", rdata, ref_mem[4]);
      end
    end
    req = 1'b0;
    chk("held_nacks", 32'(acks.size()), 32'd3);
    for (int i = 1; i < acks.size(); i++)
      chk("held_spacing", 32'(acks[i] - acks[i-1]), 32'(LATENCY + 2));
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    chk("held_drain", {31'b0, busy}, 32'h0);

    // Reset during WAIT abandons the write
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'h1234_5678;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_ack", {31'b0, ack}, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_errs", {30'b0, err_align, err_range}, 32'h0);
    @(negedge clk) reset = 1'b1;
    txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

    // Random mix, biased toward aligned in-range accesses
    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'd3 && $urandom_range(0, 3) != 0) sz = 2'd2;
      a = {22'b0, 8'($urandom), 2'($urandom)};
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd2) a[1:0] = 2'b00;
        if (sz == 2'd1) a[0] = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) a[31:10] = 22'($urandom_range(1, 4000));
      txn(1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
